// File: rtl/ifmap_fetch_pkg.sv
// Shared definitions for the input-feature-map fetch block.
// Holds the parameter defaults, the fetch FSM state type and the
// cfg_ci-to-word-count mapping used when a fetch is started.
package ifmap_fetch_pkg;

   localparam int unsigned DEF_DATA_W     = 64;
   localparam int unsigned DEF_ADDR_W     = 32;
   localparam int unsigned DEF_FIFO_DEPTH = 8;

   // Width of the issued/consumed word counters (max total is 16384).
   localparam int unsigned CNT_W = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Words per feature map: 2048 << cfg_ci (2048/4096/8192/16384).
   function automatic logic [CNT_W-1:0] ci_words(input logic [1:0] ci);
      return CNT_W'(2048) << ci;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO used as the feature-word staging buffer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears pointers/count)
//   push_i    : write data_i this cycle
//   data_i    : write data
//   pop_i     : remove head word this cycle (ignored when empty)
//   data_o    : head word, 0 when empty
//   valid_o   : buffer not empty
//   count_o   : number of stored words
module sync_fifo
   import ifmap_fetch_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned OCC_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic [OCC_W-1:0]  count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]  count_q;
   logic              do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   // A push into a full buffer is only legal when the head leaves the same cycle.
   assign do_push = push_i && ((count_q != OCC_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + OCC_W'(1);
            2'b01:   count_q <= count_q - OCC_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign valid_o = (count_q != '0);
   // Storage is not reset, so the head is masked while empty.
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/ifmap_fetch.sv
// Input-feature-map fetch engine. On start it reads 2048<<cfg_ci words from
// consecutive addresses beginning at base_addr, stages returns in a show-ahead
// buffer for the convolution controller, and pulses done once every word has
// been consumed. Requests are credit-limited so the buffer can never overflow.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, cfg_ci,
//   base_addr            : fetch request and its configuration (sampled in IDLE)
//   mem_req, mem_addr,
//   mem_ready            : read request handshake
//   mem_rvalid, mem_rdata: in-order read returns
//   read_I               : downstream pop strobe
//   Idata, idata_valid   : head-of-buffer word and valid flag
//   busy, done           : fetch in progress / one-cycle completion pulse
module ifmap_fetch
   import ifmap_fetch_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        cfg_ci,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              read_I,
   output logic [DATA_W-1:0] Idata,
   output logic              idata_valid,
   output logic              busy,
   output logic              done
);

   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  consumed_q, consumed_d;
   logic [OCC_W-1:0]  outst_q, outst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [OCC_W-1:0]  fifo_count;
   logic [OCC_W:0]    inflight;
   logic              fire, rsp_ok, pop;

   // Buffered plus in-flight words bound the buffer occupancy. While a request
   // stalls this sum cannot grow (a return moves a word from outstanding into
   // the buffer), so mem_req stays asserted until accepted.
   assign inflight = {1'b0, fifo_count} + {1'b0, outst_q};
   assign mem_req  = (state_q == FETCH) && (inflight < (OCC_W+1)'(FIFO_DEPTH))
                     && (issued_q < total_q);
   assign fire     = mem_req && mem_ready;
   assign rsp_ok   = mem_rvalid && (outst_q != '0);
   assign pop      = read_I && idata_valid;

   always_comb begin
      state_d    = state_q;
      total_d    = total_q;
      issued_d   = issued_q;
      consumed_d = consumed_q;
      addr_d     = addr_q;
      done       = 1'b0;

      if (pop) consumed_d = consumed_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (start) begin
               total_d    = ci_words(cfg_ci);
               addr_d     = base_addr;
               issued_d   = '0;
               consumed_d = '0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            if (fire) begin
               issued_d = issued_q + CNT_W'(1);
               addr_d   = addr_q + ADDR_STEP;
            end
            if (issued_q == total_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (consumed_q == total_q) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      case ({fire, rsp_ok})
         2'b10:   outst_d = outst_q + OCC_W'(1);
         2'b01:   outst_d = outst_q - OCC_W'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         total_q    <= '0;
         issued_q   <= '0;
         consumed_q <= '0;
         outst_q    <= '0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         issued_q   <= issued_d;
         consumed_q <= consumed_d;
         outst_q    <= outst_d;
         addr_q     <= addr_d;
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp_ok),
      .data_i  (mem_rdata),
      .pop_i   (pop),
      .data_o  (Idata),
      .valid_o (idata_valid),
      .count_o (fifo_count)
   );

   assign mem_addr = addr_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ifmap_fetch.sv
module tb_ifmap_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  cfg_ci;
   logic [31:0] base_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        read_I;
   logic [63:0] Idata;
   logic        idata_valid;
   logic        busy;
   logic        done;

   ifmap_fetch #(.DATA_W(64), .FIFO_DEPTH(8), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_ci(cfg_ci), .base_addr(base_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .read_I(read_I),
      .Idata(Idata), .idata_valid(idata_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } rsp_t;

   typedef struct {
      logic [1:0]  ci;
      logic [31:0] base;
      int unsigned lat;
      int unsigned words;
   } vec_t;

   int unsigned nvec = 0;
   int unsigned nfail = 0;
   int unsigned cyc = 0;
   int unsigned lat = 3;
   rsp_t        rsp_q[$];
   logic [31:0] exp_addr, exp_pop_addr;
   int unsigned acc_cnt, pop_cnt, done_cnt, last_pop_cyc, done_cyc;

   function automatic logic [63:0] mkdata(input logic [31:0] a);
      return {a ^ 32'h5A5AC3C3, a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Samples on the falling edge: request/pop handshakes seen here take effect
   // at the next rising edge. Also acts as the memory, returning data a fixed
   // number of cycles after each accepted request.
   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (mem_req && mem_ready) begin
               check("mem_addr", mem_addr, exp_addr);
               rsp_q.push_back('{addr: mem_addr, due: cyc + lat});
               exp_addr = exp_addr + 32'd8;
               acc_cnt++;
            end
            if (read_I && idata_valid) begin
               check("Idata", Idata, mkdata(exp_pop_addr));
               exp_pop_addr = exp_pop_addr + 32'd8;
               pop_cnt++;
               last_pop_cyc = cyc;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
         if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mkdata(rsp_q[0].addr);
            void'(rsp_q.pop_front());
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(input logic [1:0] ci, input logic [31:0] base);
      exp_addr     = base;
      exp_pop_addr = base;
      acc_cnt      = 0;
      pop_cnt      = 0;
      done_cnt     = 0;
      last_pop_cyc = 0;
      done_cyc     = 0;
      cfg_ci       = ci;
      base_addr    = base;
      start        = 1'b1;
      tick();
      start        = 1'b0;
      // Scramble the config inputs: the DUT must have latched them.
      cfg_ci       = 2'd3;
      base_addr    = 32'hDEAD0000;
   endtask

   task automatic wait_done(input string name, input int unsigned budget);
      int unsigned n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      check({name, "_done_seen"}, (done_cnt != 0), 1'b1);
   endtask

   task automatic finish_checks(input string name, input int unsigned words);
      repeat (3) tick();
      check({name, "_busy_after"}, busy, 1'b0);
      check({name, "_req_after"}, mem_req, 1'b0);
      check({name, "_accepts"}, acc_cnt, words);
      check({name, "_pops"}, pop_cnt, words);
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_done_timing"}, done_cyc, last_pop_cyc + 1);
   endtask

   initial begin
      vec_t vt[4];
      int unsigned n;

      vt[0] = '{ci: 2'd0, base: 32'h00001000, lat: 3, words: 2048};
      vt[1] = '{ci: 2'd1, base: 32'h20000000, lat: 1, words: 4096};
      vt[2] = '{ci: 2'd2, base: 32'h00000010, lat: 5, words: 8192};
      vt[3] = '{ci: 2'd3, base: 32'h80000000, lat: 2, words: 16384};

      rst = 1'b1; start = 1'b0; cfg_ci = 2'd0; base_addr = '0;
      mem_ready = 1'b1; read_I = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      exp_addr = '0; exp_pop_addr = '0;
      acc_cnt = 0; pop_cnt = 0; done_cnt = 0; last_pop_cyc = 0; done_cyc = 0;
      fork
         monitor();
      join_none

      repeat (3) tick();
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_idata_valid", idata_valid, 1'b0);
      check("rst_Idata", Idata, 64'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst = 1'b0;
      tick();

      // Full runs for every cfg_ci with free-flowing memory and consumer.
      read_I = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         lat = vt[i].lat;
         begin_run(vt[i].ci, vt[i].base);
         check($sformatf("v%0d_busy", i), busy, 1'b1);
         wait_done($sformatf("v%0d", i), vt[i].words * 4 + 200);
         finish_checks($sformatf("v%0d", i), vt[i].words);
      end

      // Consumer stalled: credits stop requests at the buffer depth.
      lat = 3;
      read_I = 1'b0;
      begin_run(2'd0, 32'h00000100);
      repeat (40) tick();
      check("stall_accepts", acc_cnt, 8);
      check("stall_req", mem_req, 1'b0);
      check("stall_valid", idata_valid, 1'b1);
      check("stall_head", Idata, mkdata(32'h00000100));
      check("stall_busy", busy, 1'b1);
      read_I = 1'b1;
      wait_done("stall", 2048 * 4 + 200);
      finish_checks("stall", 2048);

      // Memory backpressure on the third request.
      begin_run(2'd0, 32'h00004000);
      n = 0;
      while (acc_cnt < 2 && n < 50) begin
         tick();
         n++;
      end
      check("bp_reach_req3", acc_cnt, 2);
      mem_ready = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_req_held", mem_req, 1'b1);
         check("bp_addr_held", mem_addr, 32'h00004010);
      end
      tick();
      mem_ready = 1'b1;
      check("bp_no_accept_in_stall", acc_cnt, 2);
      wait_done("bp", 2048 * 4 + 200);
      finish_checks("bp", 2048);

      // Reset mid-fetch with requests in flight; late returns must be dropped.
      lat = 6;
      begin_run(2'd0, 32'h00020000);
      n = 0;
      while (acc_cnt < 100 && n < 1000) begin
         tick();
         n++;
      end
      check("mr_reach_100", acc_cnt, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_valid", idata_valid, 1'b0);
      check("mr_busy", busy, 1'b0);
      check("mr_req", mem_req, 1'b0);
      check("mr_addr", mem_addr, 32'h0);
      for (int unsigned i = 0; i < 12; i++) begin
         tick();
         check("mr_late_ignored", idata_valid, 1'b0);
      end
      check("mr_pops_after_rst", pop_cnt, 100 - (100 - pop_cnt));
      begin_run(2'd0, 32'h00030000);
      wait_done("mr_rerun", 2048 * 4 + 200);
      finish_checks("mr_rerun", 2048);

      // Address wrap, extra starts during the fetch, pops while empty.
      lat = 3;
      begin_run(2'd0, 32'hFFFFFFF8);
      n = 0;
      while (acc_cnt < 1 && n < 50) begin
         tick();
         n++;
      end
      check("wrap_second_addr", mem_addr, 32'h00000000);
      for (int unsigned i = 0; i < 3; i++) begin
         repeat (100) tick();
         cfg_ci = 2'd3;
         base_addr = 32'h00001234;
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      check("wrap_busy", busy, 1'b1);
      wait_done("wrap", 2048 * 4 + 200);
      finish_checks("wrap", 2048);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
